// File: rtl/pcm_pkg.sv
// pcm_pkg: shared types and helpers for the pipe commit monitor
package pcm_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_START = 2'd1,
        SEQ_RUN   = 2'd2
    } seq_state_t;

    // Flat bit position of the stall for pipe p, stage s (stages numbered from 1)
    function automatic int stall_idx(input int p, input int s, input int num_stages);
        return p * num_stages + s - 1;
    endfunction

endpackage

// File: rtl/pcm_token_pipe.sv
// pcm_token_pipe: follows the tracked token through one stall-able pipe
module pcm_token_pipe
    import pcm_pkg::*;
#(
    parameter int NUM_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_STAGES-1:0] stall,
    input  logic                  valid_s1,
    input  logic                  gate_s1,
    output logic                  commit,
    output logic                  inflight
);

    logic [NUM_STAGES:1] adv;
    logic [NUM_STAGES:2] tok;

    // S1 exists only during the launch cycle; later stages advance unless stalled
    always_comb begin
        adv[1] = start && (gate_s1 ? valid_s1 && !stall[stall_idx(0, 1, NUM_STAGES)] : 1'b1);
        for (int s = 2; s <= NUM_STAGES; s++)
            adv[s] = tok[s] && !stall[stall_idx(0, s, NUM_STAGES)];
    end

    // Stage registers hold under stall; commit is the token leaving the last stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok    <= '0;
            commit <= 1'b0;
        end else begin
            for (int s = 2; s <= NUM_STAGES; s++)
                if (!stall[stall_idx(0, s, NUM_STAGES)]) tok[s] <= adv[s-1];
            commit <= adv[NUM_STAGES];
        end
    end

    assign inflight = adv[1] || (|tok);

endmodule

// File: rtl/pipe_commit_monitor.sv
// pipe_commit_monitor: launches one tracked instruction and reports its commit/end sequencing
module pipe_commit_monitor
    import pcm_pkg::*;
#(
    parameter int NUM_PIPES  = 2,
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int CNT_SAT    = 132,
    parameter int MAX_CYCLES = 50,
    parameter int COMMIT_ALL = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue,
    input  logic [NUM_PIPES*NUM_STAGES-1:0] stall,
    input  logic [NUM_PIPES-1:0]            valid_s1,
    input  logic [NUM_PIPES-1:0]            gate_s1,
    input  logic [NUM_PIPES-1:0]            commit_mask,
    output logic                            start,
    output logic                            started,
    output logic                            ended,
    output logic                            ended2,
    output logic                            iend,
    output logic                            timeout,
    output logic [CNT_W-1:0]                cycle_cnt,
    output logic [NUM_PIPES-1:0]            commit,
    output logic [NUM_PIPES-1:0]            inflight
);

    seq_state_t           state, state_nx;
    logic [NUM_PIPES-1:0] done;
    logic                 edc;

    // Launch sequencing register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEQ_IDLE;
        else     state <= state_nx;
    end

    // One launch per reset: idle -> start pulse -> running forever
    always_comb begin
        state_nx = (state == SEQ_START) ? SEQ_RUN :
                   (state == SEQ_IDLE && issue) ? SEQ_START : state;
    end

    assign start   = (state == SEQ_START);
    assign started = (state == SEQ_RUN);

    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
        pcm_token_pipe #(.NUM_STAGES(NUM_STAGES)) u_pipe (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .stall    (stall[stall_idx(p, 1, NUM_STAGES) +: NUM_STAGES]),
            .valid_s1 (valid_s1[p]),
            .gate_s1  (gate_s1[p]),
            .commit   (commit[p]),
            .inflight (inflight[p])
        );
    end

    assign edc  = started && ((COMMIT_ALL != 0) ? (|commit_mask) && (&(done | commit | ~commit_mask))
                                                : |(commit & commit_mask));
    assign iend = !rst && edc && !ended && (cycle_cnt <= CNT_W'(MAX_CYCLES));

    // Saturating cycle counter running from the launch pulse onwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                    cycle_cnt <= '0;
        else if ((start || started) && cycle_cnt < CNT_W'(CNT_SAT)) cycle_cnt <= cycle_cnt + 1'b1;
    end

    // Sticky completion flags; ended2 sees the old ended so it lags the first end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done    <= '0;
            ended   <= 1'b0;
            ended2  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            done    <= done | commit;
            ended   <= ended | iend;
            ended2  <= ended2 | (ended && edc);
            timeout <= timeout | (started && !ended && cycle_cnt > CNT_W'(MAX_CYCLES));
        end
    end

endmodule

// File: doc/pipe_commit_monitor.md
Name: pipe_commit_monitor

Overview:
- Parametrised refinement-check monitor for the L2 ILA-vs-RTL verification wrappers.
- Issues one tracked instruction, follows its token through NUM_PIPES independent stall-able pipelines of NUM_STAGES stages, and detects commit per pipe.
- Produces START/STARTED/ENDED/2ndENDED sequencing, a bounded cycle counter and a new timeout flag for the property layer.
- Generalises the fixed two-pipe, fixed-depth monitor chain to N pipes, configurable depth, any/all commit policy and per-pipe S1 gating.

Parameters:
NUM_PIPES, 2, number of monitored pipelines
NUM_STAGES, 4, stages per pipe (S1..S<NUM_STAGES>), minimum 2
CNT_W, 8, cycle counter width
CNT_SAT, 132, counter saturation value
MAX_CYCLES, 50, iend accepted only while cycle_cnt <= MAX_CYCLES
COMMIT_ALL, 0, 0 = any masked pipe commit ends the instruction; 1 = all masked pipes must have committed

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
issue  in  1  request to launch the tracked instruction
stall  in  NUM_PIPES*NUM_STAGES  stall of pipe p, stage s at bit p*NUM_STAGES+(s-1)
valid_s1  in  NUM_PIPES  S1 valid of each pipe
gate_s1  in  NUM_PIPES  1 = pipe token enters only if valid_s1 && !stall S1; 0 = enters unconditionally
commit_mask  in  NUM_PIPES  pipes participating in end detection
start  out  1  one-cycle launch pulse
started  out  1  sticky after start
ended  out  1  sticky after first end
ended2  out  1  sticky after second end condition
iend  out  1  combinational first-end pulse
timeout  out  1  sticky: counter passed MAX_CYCLES with no end
cycle_cnt  out  CNT_W  cycles since start
commit  out  NUM_PIPES  per-pipe commit pulse
inflight  out  NUM_PIPES  pipe currently holds the token in some stage

Behaviour:
- Reset (asynchronous, active-high): all registered outputs and tokens at 0; iend forced 0 while rst is high.
- Sequencing: start <= 1 on issue when start=0 and started=0; the next cycle start <= 0 and started <= 1. Re-issue after started is ignored; launch happens exactly once per reset.
- cycle_cnt: increments while (start || started) and cnt < CNT_SAT; saturates at CNT_SAT.
- Token S1 per pipe (combinational): start && (gate_s1[p] ? valid_s1[p] && !stall[p][1] : 1).
- Stage register tok[p][s], s >= 2: loads adv[p][s-1] when !stall[p][s], otherwise holds. adv[p][1] = S1 token; adv[p][s] = tok[p][s] && !stall[p][s].
- commit[p] <= adv[p][NUM_STAGES]; unconditional register, no stall. Latency with no stalls: NUM_STAGES cycles after start.
- Per-pipe sticky done[p] set on commit[p]; cleared only by reset.
- End condition edc: started && (COMMIT_ALL ? all masked pipes have done or commit this cycle : any masked commit[p]). Empty mask means edc is never true.
- iend = edc && !ended && cycle_cnt <= MAX_CYCLES. ended <= 1 on iend.
- ended2 <= 1 when ended && edc && !ended2; the cycle that sets ended cannot also set ended2.
- timeout <= 1 when started && !ended && cycle_cnt > MAX_CYCLES. A late commit never raises iend.
- Pipe with ungated S1 stalled at S1 still has its token advance into S2 if S2 is not stalled; this matches the legacy pipe1 semantics.
- Simultaneous commits on several pipes in one cycle produce a single iend.
- Reset mid-flight clears tokens, done bits and flags immediately.

Decomposition:
- Shared package pcm_pkg: stall bit-index function, state encoding localparams, CNT_W default.
- One sub-module, pcm_token_pipe: single-pipe token shift chain (stall, valid_s1, gate_s1 -> commit, inflight), instantiated NUM_PIPES times via generate.
- Top level holds sequencing, counter, done bits, end and timeout logic.

Test Plan:
- No stalls, NUM_PIPES=2, mask=01, COMMIT_ALL=0, issue at cycle 0 -> start@1, commit[0]@5, iend@5, ended@6, cycle_cnt=4 at commit.
- stall[0][3] held for 3 cycles while the token is in S3 -> commit[0] delayed exactly 3 cycles; inflight[0] stays 1 throughout.
- gate_s1[1]=1 with valid_s1[1]=0 at start -> pipe 1 never gets a token and commit[1] stays 0; mask=10 -> timeout sets at cycle_cnt=51; cycle_cnt saturates at 132.
- COMMIT_ALL=1, mask=11, pipe 1 stalled 2 extra cycles -> iend only on commit[1], 2 cycles after commit[0].
- Second issue cycle after an end with a further commit -> ended2 sets one cycle after that commit; start does not re-pulse.
- Assert rst mid-flight with token in S3 -> all outputs 0 asynchronously; a new issue after release relaunches cleanly.
